mdu: RTL and testbench



---
 rtl/mdu.sv | 171 +++++++++++++++++
 tb/tb_mdu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative RV M-extension multiply/divide unit, radix-2, one op in flight.
// Define MDU_DIV_EN to build the divider; otherwise div ops flag o_mdu_ill.
module mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mdu_valid,
    output logic                  o_mdu_ready,
    input  logic [2:0]            i_mdu_type,
    input  logic [DATA_WIDTH-1:0] i_mdu_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_mdu_rs2_data,
    input  logic                  i_mdu_flush,
    output logic                  o_mdu_valid,
    input  logic                  i_mdu_ready,
    output logic [DATA_WIDTH-1:0] o_mdu_res,
    output logic                  o_mdu_ill
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           typ_q;
    logic                 neg_q;
    logic [W-1:0]         a_q;
    logic [2*W-1:0]       acc_q;
    logic [W-1:0]         res_q;
    logic                 ill_q;
    logic                 vld_q;

    logic         accept, rq_div, s1, s2, n1, n2, rq_neg;
    logic [W-1:0] mag1, mag2;
    logic         fast, fast_ill;
    logic [W-1:0] fast_res;
    logic         last;

    always_comb begin
        accept = (state_q == IDLE) && i_mdu_valid && !i_mdu_flush;
        rq_div = i_mdu_type[2];
        s1     = i_mdu_type inside {3'd1, 3'd2, 3'd4, 3'd6};
        s2     = i_mdu_type inside {3'd1, 3'd4, 3'd6};
        n1     = s1 & i_mdu_rs1_data[W-1];
        n2     = s2 & i_mdu_rs2_data[W-1];
        mag1   = n1 ? -i_mdu_rs1_data : i_mdu_rs1_data;
        mag2   = n2 ? -i_mdu_rs2_data : i_mdu_rs2_data;
        // REM follows the dividend; everything else uses the sign product
        rq_neg = (i_mdu_type == 3'd6) ? n1 : (n1 ^ n2);
        last   = (cnt_q == CNT_WIDTH'(W - 1));
    end

`ifdef MDU_DIV_EN
    always_comb begin
        fast     = 1'b0;
        fast_ill = 1'b0;
        fast_res = '0;
        if (rq_div && i_mdu_rs2_data == '0) begin
            fast     = 1'b1;
            fast_res = i_mdu_type[1] ? i_mdu_rs1_data : '1;
        end else if (rq_div && !i_mdu_type[0]
                     && i_mdu_rs1_data == {1'b1, {(W-1){1'b0}}}
                     && i_mdu_rs2_data == '1) begin
            fast     = 1'b1;
            fast_res = i_mdu_type[1] ? '0 : i_mdu_rs1_data;
        end
    end
`else
    always_comb begin
        fast     = rq_div;
        fast_ill = rq_div;
        fast_res = '0;
    end
`endif

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nxt, mul_fin, step;
    logic [W-1:0]   fin_res;
`ifdef MDU_DIV_EN
    logic [W:0]     rem_sh, diff;
    logic           qbit;
    logic [2*W-1:0] div_nxt;
    logic [W-1:0]   div_val;
`endif

    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        mul_nxt = {mul_sum, acc_q[W-1:1]};
        mul_fin = neg_q ? -mul_nxt : mul_nxt;
        step    = mul_nxt;
        fin_res = (typ_q == 3'd0) ? mul_fin[W-1:0]
                                  : mul_fin[2*W-1:W];
`ifdef MDU_DIV_EN
        // restoring step: acc holds {remainder, dividend/quotient}
        rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
        diff    = rem_sh - {1'b0, a_q};
        qbit    = !diff[W];
        div_nxt = {qbit ? diff[W-1:0] : rem_sh[W-1:0],
                   acc_q[W-2:0], qbit};
        div_val = typ_q[1] ? div_nxt[2*W-1:W] : div_nxt[W-1:0];
        if (typ_q[2]) begin
            step    = div_nxt;
            fin_res = neg_q ? -div_val : div_val;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : CALC;
            CALC: if (last) state_d = DONE;
            DONE: if (vld_q && i_mdu_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_mdu_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            typ_q <= '0;
            neg_q <= 1'b0;
            a_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            ill_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            // valid trails DONE entry by one cycle
            vld_q <= (state_q == DONE) && !(vld_q && i_mdu_ready)
                   && !i_mdu_flush;
            if (accept) begin
                typ_q <= i_mdu_type;
                neg_q <= rq_neg;
                cnt_q <= '0;
                a_q   <= rq_div ? mag2 : mag1;
                acc_q <= {{W{1'b0}}, rq_div ? mag1 : mag2};
                if (fast) begin
                    res_q <= fast_res;
                    ill_q <= fast_ill;
                end
            end else if (state_q == CALC && !i_mdu_flush) begin
                acc_q <= step;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    res_q <= fin_res;
                    ill_q <= 1'b0;
                end
            end
        end
    end

    assign o_mdu_ready = (state_q == IDLE);
    assign o_mdu_valid = vld_q;
    assign o_mdu_res   = res_q;
    assign o_mdu_ill   = ill_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed table, corner sequences,
// random ops against a plain-arithmetic model, plus a W=64 instance.
module tb_mdu;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, rdy_o, flush, vo, rdy_i, ill;
    logic [2:0]  typ;
    logic [31:0] rs1, rs2, res;

    logic        v64, rdy_o64, vo64, rdy_i64, ill64;
    logic [2:0]  typ64;
    logic [63:0] a64, b64, res64;

    always #5 clk = ~clk;

    mdu #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mdu_valid(v), .o_mdu_ready(rdy_o),
        .i_mdu_type(typ),
        .i_mdu_rs1_data(rs1), .i_mdu_rs2_data(rs2),
        .i_mdu_flush(flush),
        .o_mdu_valid(vo), .i_mdu_ready(rdy_i),
        .o_mdu_res(res), .o_mdu_ill(ill)
    );

    mdu #(.DATA_WIDTH(64)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mdu_valid(v64), .o_mdu_ready(rdy_o64),
        .i_mdu_type(typ64),
        .i_mdu_rs1_data(a64), .i_mdu_rs2_data(b64),
        .i_mdu_flush(flush),
        .o_mdu_valid(vo64), .i_mdu_ready(rdy_i64),
        .o_mdu_res(res64), .o_mdu_ill(ill64)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // reference: RV M semantics from plain arithmetic
    task automatic model(input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic il, output int lat);
        logic signed [63:0] sa, sb, p;
        logic [63:0] u;
        int ia, ib;
        il  = 1'b0;
        lat = W + 1;
        r   = '0;
        ia  = a;
        ib  = b;
        u   = {32'b0, a} * {32'b0, b};
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        if (t[2] && !DIV_EN) begin
            il  = 1'b1;
            lat = 1;
        end else begin
            case (t)
                3'd0: r = u[31:0];
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin
                    sb = {32'b0, b};
                    p  = sa * sb;
                    r  = p[63:32];
                end
                3'd3: r = u[63:32];
                default: begin
                    if (b == 0) begin
                        lat = 1;
                        r   = t[1] ? a : 32'hFFFF_FFFF;
                    end else if (!t[0] && a == 32'h8000_0000
                                 && b == 32'hFFFF_FFFF) begin
                        lat = 1;
                        r   = t[1] ? 32'h0 : a;
                    end else begin
                        case (t)
                            3'd4: r = 32'(ia / ib);
                            3'd5: r = a / b;
                            3'd6: r = 32'(ia % ib);
                            default: r = a % b;
                        endcase
                    end
                end
            endcase
        end
    endtask

    // entered and left at 1 time unit after a rising edge
    task automatic do_op(input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic il, input int lat,
                         input string nm);
        int c;
        typ = t; rs1 = a; rs2 = b; v = 1'b1;
        chk({nm, "_rdy"}, 64'(rdy_o), 64'd1);
        @(posedge clk); #1;
        v = 1'b0; rs1 = $urandom; rs2 = $urandom;
        c = 0;
        while (!vo && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, "_lat"}, 64'(c), 64'(lat));
        chk({nm, "_res"}, 64'(res), 64'(r));
        chk({nm, "_ill"}, 64'(ill), 64'(il));
        rdy_i = 1'b1;
        @(posedge clk); #1;
        rdy_i = 1'b0;
        chk({nm, "_drop"}, 64'(vo), 64'd0);
    endtask

    task automatic do_op64(input logic [2:0] t, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] r,
                           input logic il, input int lat,
                           input string nm);
        int c;
        typ64 = t; a64 = a; b64 = b; v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        c = 0;
        while (!vo64 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, "_lat"}, 64'(c), 64'(lat));
        chk({nm, "_res"}, res64, r);
        chk({nm, "_ill"}, 64'(ill64), 64'(il));
        rdy_i64 = 1'b1;
        @(posedge clk); #1;
        rdy_i64 = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] x;
        case ($urandom_range(0, 4))
            0: x = 32'h0;
            1: x = 32'hFFFF_FFFF;
            2: x = 32'h8000_0000;
            3: x = 32'($urandom_range(0, 9));
            default: x = $urandom;
        endcase
        return x;
    endfunction

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        il;
        int          lat;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] er, x, y;
        logic        eil;
        int          elat;
        logic [2:0]  rt;
        logic        seen;

        rst_n = 1'b0; flush = 1'b0;
        v = 1'b0; rdy_i = 1'b0; typ = '0; rs1 = '0; rs2 = '0;
        v64 = 1'b0; rdy_i64 = 1'b0; typ64 = '0; a64 = '0; b64 = '0;

        tbl.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB,
                        1'b0, 33, "mul"});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFE, 1'b0, 33, "mulhu"});
        tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'h0, 1'b0, 33, "mulh"});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                        1'b0, 33, "mulhsu"});
`ifdef MDU_DIV_EN
        tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
                        32'h8000_0000, 1'b0, 1, "div_ovf"});
        tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
                        32'h0, 1'b0, 1, "rem_ovf"});
        tbl.push_back('{3'd5, 32'd13, 32'd0, 32'hFFFF_FFFF,
                        1'b0, 1, "divu_z"});
        tbl.push_back('{3'd7, 32'd13, 32'd0, 32'd13,
                        1'b0, 1, "remu_z"});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF,
                        1'b0, 33, "rem_neg"});
        tbl.push_back('{3'd5, 32'd10, 32'd3, 32'd3,
                        1'b0, 33, "divu"});
`else
        tbl.push_back('{3'd5, 32'd10, 32'd3, 32'd0,
                        1'b1, 1, "divu_ill"});
        tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
                        32'd0, 1'b1, 1, "div_ill"});
        tbl.push_back('{3'd7, 32'd13, 32'd0, 32'd0,
                        1'b1, 1, "remu_ill"});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy_o), 64'd1);
        chk("rst_valid", 64'(vo), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_ill", 64'(ill), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            do_op(tbl[i].t, tbl[i].a, tbl[i].b, tbl[i].r,
                  tbl[i].il, tbl[i].lat, tbl[i].nm);

        // backpressure: result held, unit busy
        typ = 3'd0; rs1 = 32'd3; rs2 = 32'd5; v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 64'(vo), 64'd1);
            chk("bp_res", 64'(res), 64'd15);
            chk("bp_ready", 64'(rdy_o), 64'd0);
            @(posedge clk); #1;
        end
        rdy_i = 1'b1;
        @(posedge clk); #1;
        rdy_i = 1'b0;
        chk("bp_ready_back", 64'(rdy_o), 64'd1);
        do_op(3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 33, "bp_next");

        // flush in CALC with a request in the same cycle
        typ = 3'd0; rs1 = 32'd9; rs2 = 32'd9; v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1; v = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; v = 1'b0;
        chk("flush_ready", 64'(rdy_o), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            seen |= vo;
        end
        chk("flush_noresult", 64'(seen), 64'd0);

        // asynchronous reset mid-CALC
        typ = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3; v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(rdy_o), 64'd1);
        chk("arst_valid", 64'(vo), 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(3'd3, 32'hFFFF_FFFF, 32'd3, 32'd2, 1'b0, 33, "post_rst");

        // flush beats the result handshake
        typ = 3'd0; rs1 = 32'd2; rs2 = 32'd2; v = 1'b1;
        @(posedge clk); #1;
        v = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        chk("fh_valid", 64'(vo), 64'd1);
        flush = 1'b1; rdy_i = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; rdy_i = 1'b0;
        chk("fh_valid_gone", 64'(vo), 64'd0);
        chk("fh_ready", 64'(rdy_o), 64'd1);

        // randomized against the model
        for (int k = 0; k < 40; k++) begin
            rt = 3'($urandom_range(0, 7));
            x  = pick();
            y  = pick();
            model(rt, x, y, er, eil, elat);
            do_op(rt, x, y, er, eil, elat, $sformatf("rnd%0d", k));
        end

        // W=64 instance
        do_op64(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65, "mul64");
        do_op64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                64'd1, 1'b0, 65, "mulhu64");
`ifdef MDU_DIV_EN
        do_op64(3'd5, 64'd10, 64'd3, 64'd3, 1'b0, 65, "divu64");
`else
        do_op64(3'd5, 64'd10, 64'd3, 64'd0, 1'b1, 1, "divu64_ill");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
